// File: rtl/yuv_rgb_pkg.sv
// Shared constants, pixel layouts and the output clamp for the
// BT.601 studio-range YUV to full-range RGB conversion.
package yuv_rgb_pkg;

  // Studio-range offsets removed from luma and chroma before scaling
  localparam int Y_OFS = 16;
  localparam int C_OFS = 128;

  // Fixed-point coefficients in units of 1/256
  localparam int K_Y        = 298;
  localparam int K_RV       = 409;
  localparam int K_GU       = 100;
  localparam int K_GV       = 208;
  localparam int K_BU       = 516;
  localparam int COEF_SHIFT = 8;
  localparam int ROUND      = 128;

  // Width of products and sums; large enough for every in-range combination
  localparam int PROD_W = 20;
  localparam int PIX_W  = 32;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv_pix_t;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  // Saturate a scaled channel value into the 0..255 byte range
  function automatic logic [7:0] clamp_u8(input logic signed [PROD_W-1:0] x);
    if (x < 20'sd0) begin
      return 8'h00;
    end else if (x > 20'sd255) begin
      return 8'hFF;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/yuv2rgb_pixel_pipe.sv
// Datapath for one 32-bit pixel lane: offset removal, coefficient
// products, then rounded sums with clamping. Load enables come from
// the top-level valid/ready control; this block holds no valid state.
module yuv2rgb_pixel_pipe
  import yuv_rgb_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_en1,
  input  logic              i_en2,
  input  logic              i_en3,
  input  logic [PIX_W-1:0]  i_pix,
  output logic [PIX_W-1:0]  o_pix
);

  yuv_pix_t w_in;
  assign w_in = yuv_pix_t'(i_pix);

  // The top byte of an input lane carries no information and is dropped
  logic w_unused_pad;
  assign w_unused_pad = ^w_in.pad;

  logic signed [9:0] w_yd;
  logic signed [8:0] w_ud;
  logic signed [8:0] w_vd;
  assign w_yd = {2'b00, w_in.y} - 10'(Y_OFS);
  assign w_ud = {1'b0, w_in.u} - 9'(C_OFS);
  assign w_vd = {1'b0, w_in.v} - 9'(C_OFS);

  logic signed [9:0] r_yd;
  logic signed [8:0] r_ud;
  logic signed [8:0] r_vd;

  // Stage 1: capture the offset-removed luma and chroma
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_yd <= '0;
      r_ud <= '0;
      r_vd <= '0;
    end else if (i_en1) begin
      r_yd <= w_yd;
      r_ud <= w_ud;
      r_vd <= w_vd;
    end
  end

  logic signed [PROD_W-1:0] w_yd_x;
  logic signed [PROD_W-1:0] w_ud_x;
  logic signed [PROD_W-1:0] w_vd_x;
  assign w_yd_x = {{(PROD_W-10){r_yd[9]}}, r_yd};
  assign w_ud_x = {{(PROD_W-9){r_ud[8]}}, r_ud};
  assign w_vd_x = {{(PROD_W-9){r_vd[8]}}, r_vd};

  logic signed [PROD_W-1:0] r_py;
  logic signed [PROD_W-1:0] r_prv;
  logic signed [PROD_W-1:0] r_pgu;
  logic signed [PROD_W-1:0] r_pgv;
  logic signed [PROD_W-1:0] r_pbu;

  // Stage 2: register the five coefficient products (green terms negated)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_py  <= '0;
      r_prv <= '0;
      r_pgu <= '0;
      r_pgv <= '0;
      r_pbu <= '0;
    end else if (i_en2) begin
      r_py  <= w_yd_x * 20'(K_Y);
      r_prv <= w_vd_x * 20'(K_RV);
      r_pgu <= -(w_ud_x * 20'(K_GU));
      r_pgv <= -(w_vd_x * 20'(K_GV));
      r_pbu <= w_ud_x * 20'(K_BU);
    end
  end

  logic signed [PROD_W-1:0] w_r_sum;
  logic signed [PROD_W-1:0] w_g_sum;
  logic signed [PROD_W-1:0] w_b_sum;
  logic signed [PROD_W-1:0] w_r_sh;
  logic signed [PROD_W-1:0] w_g_sh;
  logic signed [PROD_W-1:0] w_b_sh;
  assign w_r_sum = r_py + r_prv + 20'(ROUND);
  assign w_g_sum = r_py + r_pgu + r_pgv + 20'(ROUND);
  assign w_b_sum = r_py + r_pbu + 20'(ROUND);
  assign w_r_sh  = w_r_sum >>> COEF_SHIFT;
  assign w_g_sh  = w_g_sum >>> COEF_SHIFT;
  assign w_b_sh  = w_b_sum >>> COEF_SHIFT;

  rgb_pix_t r_out;

  // Stage 3: rounded, scaled and clamped RGB with the pad byte zeroed
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out <= '0;
    end else if (i_en3) begin
      r_out.pad <= 8'h00;
      r_out.r   <= clamp_u8(w_r_sh);
      r_out.g   <= clamp_u8(w_g_sh);
      r_out.b   <= clamp_u8(w_b_sh);
    end
  end

  assign o_pix = r_out;

endmodule

// File: rtl/yuv444_to_rgb.sv
// Packed 4:4:4 YUV to XRGB8888 stream converter. Three register stages
// with per-stage valid; a stage loads whenever it is empty or the stage
// after it is moving, so bubbles collapse while the output is stalled.
module yuv444_to_rgb
  import yuv_rgb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic [DATA_WIDTH/8-1:0] src_t_strb,
  input  logic [DATA_WIDTH/8-1:0] src_t_keep,
  input  logic                    src_t_last,
  input  logic [ID_WIDTH-1:0]     src_t_id,
  input  logic [DEST_WIDTH-1:0]   src_t_dest,
  input  logic [USER_WIDTH-1:0]   src_t_user,

  output logic                    dst_t_valid,
  input  logic                    dst_t_ready,
  output logic [DATA_WIDTH-1:0]   dst_t_data,
  output logic [DATA_WIDTH/8-1:0] dst_t_strb,
  output logic [DATA_WIDTH/8-1:0] dst_t_keep,
  output logic                    dst_t_last,
  output logic [ID_WIDTH-1:0]     dst_t_id,
  output logic [DEST_WIDTH-1:0]   dst_t_dest,
  output logic [USER_WIDTH-1:0]   dst_t_user
);

  localparam int PIXELS = DATA_WIDTH / PIX_W;

  typedef struct packed {
    logic                    last;
    logic [DATA_WIDTH/8-1:0] keep;
    logic [DATA_WIDTH/8-1:0] strb;
    logic [ID_WIDTH-1:0]     id;
    logic [DEST_WIDTH-1:0]   dest;
    logic [USER_WIDTH-1:0]   user;
  } side_t;

  logic r_v1;
  logic r_v2;
  logic r_v3;
  logic w_rdy1;
  logic w_rdy2;
  logic w_rdy3;

  assign w_rdy3      = !r_v3 || dst_t_ready;
  assign w_rdy2      = !r_v2 || w_rdy3;
  assign w_rdy1      = !r_v1 || w_rdy2;
  assign src_t_ready = w_rdy1;
  assign dst_t_valid = r_v3;

  // Advance the per-stage valid bits; a ready stage takes its predecessor's valid
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_rdy1) r_v1 <= src_t_valid;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) r_v3 <= r_v2;
    end
  end

  side_t w_sb_in;
  side_t r_sb1;
  side_t r_sb2;
  side_t r_sb3;

  assign w_sb_in = '{last: src_t_last, keep: src_t_keep, strb: src_t_strb,
                     id: src_t_id, dest: src_t_dest, user: src_t_user};

  // Carry sideband fields alongside the pixel data with the same load enables
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sb1 <= '0;
      r_sb2 <= '0;
      r_sb3 <= '0;
    end else begin
      if (w_rdy1) r_sb1 <= w_sb_in;
      if (w_rdy2) r_sb2 <= r_sb1;
      if (w_rdy3) r_sb3 <= r_sb2;
    end
  end

  logic [DATA_WIDTH-1:0] w_dst_data;

  for (genvar p = 0; p < PIXELS; p++) begin : g_lane
    yuv2rgb_pixel_pipe u_pipe (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_en1   (w_rdy1),
      .i_en2   (w_rdy2),
      .i_en3   (w_rdy3),
      .i_pix   (src_t_data[p*PIX_W +: PIX_W]),
      .o_pix   (w_dst_data[p*PIX_W +: PIX_W])
    );
  end

  assign dst_t_data = w_dst_data;
  assign dst_t_last = r_sb3.last;
  assign dst_t_keep = r_sb3.keep;
  assign dst_t_strb = r_sb3.strb;
  assign dst_t_id   = r_sb3.id;
  assign dst_t_dest = r_sb3.dest;
  assign dst_t_user = r_sb3.user;

endmodule
